// File: rtl/count_checker_if.sv
// Bus bundle between the counter-side stimulus and count_checker.
// master drives the sampled count and strobe; slave is the checker itself.
interface count_checker_if #(
    parameter int WIDTH = 9,
    parameter int ERR_W = 8
);
    logic             enable;
    logic [WIDTH-1:0] count;
    logic             locked;
    logic             mismatch;
    logic             wrap;
    logic [WIDTH-1:0] expected;
    logic [ERR_W-1:0] err_count;

    modport master (
        output enable, count,
        input  locked, mismatch, wrap, expected, err_count
    );

    modport slave (
        input  enable, count,
        output locked, mismatch, wrap, expected, err_count
    );
endinterface

// File: rtl/count_checker.sv
// Locks onto an incrementing counter and flags every deviation with a saturating tally.
// Optional COUNT_CHECK_STALL_EN: a repeated value is accepted as a legal hold.
module count_checker #(
    parameter int WIDTH       = 9,
    parameter int LOCK_CYCLES = 4,
    parameter int ERR_W       = 8
) (
    input  logic            clock,
    input  logic            reset,
    count_checker_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] prev, prev_nxt;
    logic [WIDTH-1:0] expected_q, expected_nxt;
    logic [3:0]       run, run_nxt, run_inc;
    logic             mismatch_q, mismatch_nxt;
    logic             wrap_q, wrap_nxt;
    logic [ERR_W-1:0] err_q, err_nxt;
    logic [WIDTH-1:0] inc;
    logic             hit, at_max, stall;

    assign inc     = prev + WIDTH'(1);
    assign hit     = (bus.count == inc);
    assign at_max  = &prev;
    assign run_inc = run + 4'd1;

`ifdef COUNT_CHECK_STALL_EN
    assign stall = (bus.count == prev);
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        prev_nxt     = prev;
        run_nxt      = run;
        mismatch_nxt = 1'b0;
        wrap_nxt     = 1'b0;
        err_nxt      = err_q;
        if (bus.enable) begin
            case (state)
                IDLE: begin
                    prev_nxt  = bus.count;
                    run_nxt   = '0;
                    state_nxt = ACQ;
                end
                ACQ: if (!stall) begin
                    prev_nxt = bus.count;
                    if (hit) begin
                        run_nxt = run_inc;
                        if (run_inc == 4'(LOCK_CYCLES)) state_nxt = LOCKED;
                    end else begin
                        run_nxt = '0;
                    end
                end
                LOCKED: if (!stall) begin
                    prev_nxt = bus.count;
                    if (hit) begin
                        wrap_nxt = at_max;
                    end else begin
                        // An error outranks a coincident max->x wrap.
                        mismatch_nxt = 1'b1;
                        if (err_q != '1) err_nxt = err_q + ERR_W'(1);
                        run_nxt   = '0;
                        state_nxt = ACQ;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
        expected_nxt = (state_nxt == IDLE) ? '0 : prev_nxt + WIDTH'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            prev       <= '0;
            run        <= '0;
            mismatch_q <= 1'b0;
            wrap_q     <= 1'b0;
            expected_q <= '0;
            err_q      <= '0;
        end else begin
            state      <= state_nxt;
            prev       <= prev_nxt;
            run        <= run_nxt;
            mismatch_q <= mismatch_nxt;
            wrap_q     <= wrap_nxt;
            expected_q <= expected_nxt;
            err_q      <= err_nxt;
        end
    end

    assign bus.locked    = (state == LOCKED);
    assign bus.mismatch  = mismatch_q;
    assign bus.wrap      = wrap_q;
    assign bus.expected  = expected_q;
    assign bus.err_count = err_q;
endmodule

// File: doc/count_checker.md
# count_checker

Consumer-side checker for the free-running binary counter driven in the counter testbench. It samples the counter's `count` bus each enabled clock, locks onto the increment sequence, then flags every deviation (skip, jump, premature wrap, reset glitch). It sits in the testbench next to the counter instance and replaces eyeballing `$monitor` output with registered pass/fail status and a saturating error tally.

## Interface
- `WIDTH`, 9: width of the observed count bus.
- `LOCK_CYCLES`, 4: consecutive correct increments required to enter LOCKED (legal range 1..15).
- `ERR_W`, 8: width of the error counter.
- `clock`  in  1  sampling clock, same clock as the counter under observation.
- `reset`  in  1  synchronous, active-high reset; the only reset in the block.
- `enable`  in  1  sample strobe; when low the block holds all state.
- `count`  in  WIDTH  observed counter value.
- `locked`  out  1  high while in LOCKED.
- `mismatch`  out  1  one-cycle pulse per detected error.
- `wrap`  out  1  one-cycle pulse when a legal max→0 wrap is checked in LOCKED.
- `expected`  out  WIDTH  value required on the next enabled sample.
- `err_count`  out  ERR_W  saturating error tally.

## Operation
- States: IDLE, ACQ, LOCKED. Internal: `prev` (WIDTH), `run` (4 bits).
- Increment rule: next = (prev + 1) mod 2^WIDTH; max is 2^WIDTH−1 wrapping to 0.
- IDLE, enabled sample: `prev`←count, `run`←0, go to ACQ.
- ACQ, enabled sample: if count == prev+1, `run`←run+1 and, when run+1 == LOCK_CYCLES, go to LOCKED; otherwise `run`←0. `prev`←count in both cases. No `mismatch` in ACQ.
- LOCKED, enabled sample:
  - count == prev+1: `prev`←count. `wrap` pulses if prev == max.
  - Otherwise: `mismatch` pulses, `err_count`←err_count+1 (saturating at 2^ERR_W−1), `prev`←count, `run`←0, go to ACQ.
- `expected` = prev+1 (mod 2^WIDTH). It is registered and is valid in ACQ and LOCKED. It is 0 in IDLE.
- `enable` low: no state change; `mismatch` and `wrap` stay 0.
- Simultaneous mismatch and would-be wrap (e.g. max→5): only `mismatch` pulses.
- Error saturation: once `err_count` reaches all-ones, further mismatches still pulse `mismatch` but the count holds.

## Timing
- All outputs are registered. A sample at edge N is reflected on outputs after edge N.
- Reset has priority over `enable`. While `reset` is high at an edge: state=IDLE, `prev`=0, `run`=0, `locked`=0, `mismatch`=0, `wrap`=0, `expected`=0, `err_count`=0.
- Reset mid-LOCKED: the next edge clears everything, including `err_count`. No `mismatch` is generated for the reset cycle.
- Minimum time to lock: 1 (IDLE capture) + LOCK_CYCLES enabled samples. `locked` rises after the edge of the final qualifying sample.
- `mismatch` and `wrap` are high for exactly one cycle per event.

## Configuration
- `COUNT_CHECK_STALL_EN` defined: in ACQ and LOCKED, count == prev is treated as a legal stall.
  - It causes no state change, no `run` increment, no `mismatch`, and leaves `expected` unchanged.
  - This supports counters with a hold/enable.
- Not defined: a repeated value is an ordinary deviation. It is a `mismatch` in LOCKED and resets `run` in ACQ.

## Test plan
- Reset, then enable with count 0,1,2,3,4 (LOCK_CYCLES=4) -> `locked`=1 after the sample of 4, `expected`=5, `err_count`=0, no `mismatch`.
- Locked at 509, then count 510,511,0,1 -> single `wrap` pulse after the sample of 0, `expected`=2, no `mismatch`.
- Locked at 20, then count 22 -> `mismatch` pulse, `err_count`=1, `locked`=0, `expected`=23. Then 23,24,25,26 -> relocks.
- Locked at 100, then count 100 repeated -> with `COUNT_CHECK_STALL_EN`: no `mismatch`, `expected`=101. Without it: `mismatch`, `err_count`=1.
- ERR_W=2, force 5 mismatches with relock between each -> `err_count` saturates at 3, and 5 `mismatch` pulses are seen.
- Locked with `err_count`=2, assert `reset` one cycle with `enable`=1 and count jumping -> all outputs 0, state IDLE, no `mismatch`. `enable` low for 10 cycles with changing count -> outputs frozen.
